// File: rtl/bcd_timekeeper_if.sv
// bcd_timekeeper_if: controls, display index and status outputs of the BCD timekeeper.
interface bcd_timekeeper_if;
  logic       mode_12h;
  logic       adj_hrs;
  logic       adj_min;
  logic       adj_sec;
  logic [5:0] x_block;
  logic [3:0] number;
  logic       pm;
  logic       sec_strobe;
  logic [3:0] color_offset;
  modport master (
    output mode_12h, adj_hrs, adj_min, adj_sec, x_block,
    input  number, pm, sec_strobe, color_offset
  );
  modport slave (
    input  mode_12h, adj_hrs, adj_min, adj_sec, x_block,
    output number, pm, sec_strobe, color_offset
  );
endinterface

// File: rtl/bcd_timekeeper.sv
// bcd_timekeeper: BCD hh:mm:ss core with prescaler, adjust buttons and glyph lookup.
// Optional COLON_BLINK_EN blanks the colons during the second half of each second.
module bcd_timekeeper #(
  parameter int TICKS_PER_SEC = 31_500_000,
  parameter int FONT_W        = 4,
  parameter bit SHOW_SEC      = 1
) (
  input logic             px_clk,
  input logic             reset,
  bcd_timekeeper_if.slave tk
);
  localparam int PW = $clog2(TICKS_PER_SEC);
  localparam logic [PW-1:0] LAST = PW'(TICKS_PER_SEC - 1);
  localparam logic [5:0] CELLS = SHOW_SEC ? 6'd8 : 6'd5;
  localparam logic [3:0] COLON = 4'd10;
  localparam logic [3:0] BLANK = 4'd11;
  logic [7:0]    r_hrs, r_min, r_sec;
  logic [PW-1:0] r_presc;
  logic          r_pend, r_pm, r_strobe;
  logic [3:0]    r_number, r_color;
  logic          w_tick, w_adj, w_apply, w_min_inc, w_hrs_inc, w_pend_n;
  logic [7:0]    w_hrs_n, w_min_n, w_sec_n;
  logic [PW-1:0] w_presc_n;
  logic [4:0]    w_hb, w_hd;
  logic [3:0]    w_ht, w_hu, w_colon, w_glyph;
  logic [5:0]    w_cell;
  logic [3:0]    w_cells [8];
  function automatic logic [7:0] inc60(input logic [7:0] v);
    return v[3:0] == 4'd9 ? {v[7:4] == 4'd5 ? 4'd0 : v[7:4] + 4'd1, 4'd0} : {v[7:4], v[3:0] + 4'd1};
  endfunction
  function automatic logic [7:0] inc24(input logic [7:0] v);
    return v == 8'h23 ? 8'h00 : v[3:0] == 4'd9 ? {v[7:4] + 4'd1, 4'd0} : {v[7:4], v[3:0] + 4'd1};
  endfunction
  // Adjusts and ticks never act in the same cycle, so carries cannot collide with button edits.
  always_comb begin
    w_tick    = r_presc == LAST;
    w_adj     = tk.adj_hrs | tk.adj_min | tk.adj_sec;
    w_apply   = !w_adj && (w_tick || r_pend);
    w_min_inc = tk.adj_min || (w_apply && r_sec == 8'h59);
    w_hrs_inc = tk.adj_hrs || (w_apply && r_sec == 8'h59 && r_min == 8'h59);
    w_sec_n   = tk.adj_sec ? 8'h00 : w_apply ? inc60(r_sec) : r_sec;
    w_min_n   = w_min_inc ? inc60(r_min) : r_min;
    w_hrs_n   = w_hrs_inc ? inc24(r_hrs) : r_hrs;
    w_presc_n = (tk.adj_sec || w_tick) ? '0 : r_presc + PW'(1);
    w_pend_n  = tk.adj_sec ? 1'b0 : (w_adj && w_tick) ? 1'b1 : w_apply ? 1'b0 : r_pend;
  end
  always_comb begin
    w_hb = 5'(r_hrs[7:4]) * 5'd10 + 5'(r_hrs[3:0]);
    w_hd = w_hb == 5'd0 ? 5'd12 : w_hb > 5'd12 ? w_hb - 5'd12 : w_hb;
    w_ht = tk.mode_12h ? (w_hd >= 5'd10 ? 4'd1 : BLANK) : r_hrs[7:4];
    w_hu = tk.mode_12h ? (w_hd >= 5'd10 ? 4'(w_hd - 5'd10) : w_hd[3:0]) : r_hrs[3:0];
`ifdef COLON_BLINK_EN
    w_colon = r_presc >= PW'(TICKS_PER_SEC / 2) ? BLANK : COLON;
`else
    w_colon = COLON;
`endif
    w_cells[0] = w_ht;
    w_cells[1] = w_hu;
    w_cells[2] = w_colon;
    w_cells[3] = r_min[7:4];
    w_cells[4] = r_min[3:0];
    w_cells[5] = w_colon;
    w_cells[6] = r_sec[7:4];
    w_cells[7] = r_sec[3:0];
    w_cell     = tk.x_block / 6'(FONT_W);
    w_glyph    = w_cell < CELLS ? w_cells[w_cell[2:0]] : BLANK;
  end
  always_ff @(posedge px_clk) begin
    if (reset) begin
      r_hrs    <= '0;
      r_min    <= '0;
      r_sec    <= '0;
      r_presc  <= '0;
      r_pend   <= 1'b0;
      r_pm     <= 1'b0;
      r_strobe <= 1'b0;
      r_color  <= '0;
      r_number <= BLANK;
    end else begin
      r_hrs    <= w_hrs_n;
      r_min    <= w_min_n;
      r_sec    <= w_sec_n;
      r_presc  <= w_presc_n;
      r_pend   <= w_pend_n;
      r_pm     <= w_hrs_n >= 8'h12;
      r_strobe <= w_apply;
      r_color  <= r_color + 4'(w_min_inc);
      r_number <= w_glyph;
    end
  end
  assign tk.number       = r_number;
  assign tk.pm           = r_pm;
  assign tk.sec_strobe   = r_strobe;
  assign tk.color_offset = r_color;
endmodule

// File: tb/tb_bcd_timekeeper.sv
// tb_bcd_timekeeper: scoreboard bench for bcd_timekeeper with a 4-cycle second.
module tb_bcd_timekeeper;
  logic px_clk = 1'b0;
  logic reset  = 1'b1;
  always #5 px_clk = ~px_clk;
  bcd_timekeeper_if tk();
  bcd_timekeeper_if tk5();
  bcd_timekeeper #(.TICKS_PER_SEC(4), .FONT_W(4), .SHOW_SEC(1)) dut (
    .px_clk(px_clk), .reset(reset), .tk(tk)
  );
  bcd_timekeeper #(.TICKS_PER_SEC(4), .FONT_W(4), .SHOW_SEC(0)) dut5 (
    .px_clk(px_clk), .reset(reset), .tk(tk5)
  );
  assign tk5.mode_12h = tk.mode_12h;
  assign tk5.adj_hrs  = tk.adj_hrs;
  assign tk5.adj_min  = tk.adj_min;
  assign tk5.adj_sec  = tk.adj_sec;
  assign tk5.x_block  = tk.x_block;
  typedef struct {
    int num;
    int num5;
    int pm;
    int strobe;
    int color;
  } exp_t;
  exp_t sb[$];
  int n_checks = 0;
  int n_errors = 0;
  int ms = 0, mm = 0, mh = 0, mp = 0, mpend = 0, mcol = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask
  function automatic int glyph(input int x, input bit m12, input bit show, input int h, input int m,
                               input int s, input int p);
    int c, hd;
    c = x / 4;
    if (c >= (show ? 8 : 5)) return 11;
    hd = m12 ? (h == 0 ? 12 : (h > 12 ? h - 12 : h)) : h;
    case (c)
      0: return (m12 && hd < 10) ? 11 : hd / 10;
      1: return hd % 10;
      3: return m / 10;
      4: return m % 10;
      6: return s / 10;
      7: return s % 10;
`ifdef COLON_BLINK_EN
      default: return p >= 2 ? 11 : 10;
`else
      default: return 10;
`endif
    endcase
  endfunction
  // Reference time model: computes what each edge should produce and queues it.
  always @(posedge px_clk) begin : model
    exp_t e;
    int s, m, h, p, pd, col;
    bit tick, any, apply;
    if (reset) begin
      e = '{11, 11, 0, 0, 0};
      ms <= 0; mm <= 0; mh <= 0; mp <= 0; mpend <= 0; mcol <= 0;
    end else begin
      s = ms; m = mm; h = mh; p = mp; pd = mpend; col = mcol;
      e.num  = glyph(int'(tk.x_block), tk.mode_12h, 1'b1, h, m, s, p);
      e.num5 = glyph(int'(tk.x_block), tk.mode_12h, 1'b0, h, m, s, p);
      tick  = p == 3;
      any   = tk.adj_hrs || tk.adj_min || tk.adj_sec;
      apply = !any && (tick || pd != 0);
      pd = tk.adj_sec ? 0 : (any && tick) ? 1 : apply ? 0 : pd;
      p  = (tk.adj_sec || tick) ? 0 : p + 1;
      if (apply) begin
        s++;
        if (s == 60) begin
          s = 0; m++; col++;
          if (m == 60) begin m = 0; h = (h + 1) % 24; end
        end
      end
      if (tk.adj_sec) s = 0;
      if (tk.adj_min) begin m = (m + 1) % 60; col++; end
      if (tk.adj_hrs) h = (h + 1) % 24;
      e.pm = h >= 12 ? 1 : 0;
      e.strobe = apply ? 1 : 0;
      e.color = col % 16;
      ms <= s; mm <= m; mh <= h; mp <= p; mpend <= pd; mcol <= col;
    end
    sb.push_back(e);
  end
  always @(negedge px_clk) begin : monitor
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("sb_number", 32'(tk.number), e.num);
      check("sb_number_hhmm", 32'(tk5.number), e.num5);
      check("sb_pm", 32'(tk.pm), e.pm);
      check("sb_strobe", 32'(tk.sec_strobe), e.strobe);
      check("sb_color", 32'(tk.color_offset), e.color);
    end
  end
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge px_clk);
      #1;
    end
  endtask
  task automatic adj(input bit h, input bit m, input bit s, input int n);
    repeat (n) begin
      tk.adj_hrs = h; tk.adj_min = m; tk.adj_sec = s;
      step();
    end
    tk.adj_hrs = 1'b0; tk.adj_min = 1'b0; tk.adj_sec = 1'b0;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    step(2);
    reset = 1'b0;
  endtask
  task automatic show(input int x, input string tag, input int exp);
    tk.x_block = 6'(x);
    step();
    check(tag, 32'(tk.number), exp);
  endtask
  initial begin
    int cnt;
    int exp_colon;
    tk.mode_12h = 1'b0;
    tk.adj_hrs = 1'b0; tk.adj_min = 1'b0; tk.adj_sec = 1'b0;
    tk.x_block = 6'd0;
    do_reset();
    check("rst_number", 32'(tk.number), 11);
    check("rst_pm", 32'(tk.pm), 0);
    check("rst_strobe", 32'(tk.sec_strobe), 0);
    check("rst_color", 32'(tk.color_offset), 0);
    cnt = 0;
    repeat (240) begin
      step();
      cnt += int'(tk.sec_strobe);
    end
    check("strobe_count", cnt, 60);
    check("color_after_min", 32'(tk.color_offset), 1);
    show(16, "min_units_01", 1);
    show(28, "sec_units_00", 0);
    // Preload 23:59:59 and roll over midnight.
    do_reset();
    adj(1'b1, 1'b0, 1'b0, 23);
    adj(1'b0, 1'b1, 1'b0, 59);
    adj(1'b0, 1'b0, 1'b1, 1);
    step(236);
    check("pm_at_23", 32'(tk.pm), 1);
    check("color_before_midnight", 32'(tk.color_offset), 11);
    step(3);
    check("no_strobe_before_tick", 32'(tk.sec_strobe), 0);
    step();
    check("midnight_strobe", 32'(tk.sec_strobe), 1);
    check("midnight_pm", 32'(tk.pm), 0);
    check("midnight_color", 32'(tk.color_offset), 12);
    show(0, "midnight_h_tens", 0);
    show(28, "midnight_s_units", 0);
    // adj_min colliding with the 00:59:59 tick.
    do_reset();
    adj(1'b0, 1'b1, 1'b0, 59);
    adj(1'b0, 1'b0, 1'b1, 1);
    step(239);
    adj(1'b0, 1'b1, 1'b0, 1);
    check("deferred_no_strobe", 32'(tk.sec_strobe), 0);
    check("deferred_color_adj", 32'(tk.color_offset), 12);
    step();
    check("deferred_strobe", 32'(tk.sec_strobe), 1);
    check("deferred_color_carry", 32'(tk.color_offset), 13);
    tk.mode_12h = 1'b1;
    show(0, "h12_midnight_tens", 1);
    show(4, "h12_midnight_units", 2);
    show(16, "deferred_min_units", 1);
    do_reset();
    adj(1'b1, 1'b0, 1'b0, 13);
    show(0, "h12_13_tens", 11);
    show(4, "h12_13_units", 1);
    check("h12_13_pm", 32'(tk.pm), 1);
    tk.mode_12h = 1'b0;
    do_reset();
    adj(1'b1, 1'b0, 1'b0, 7);
    show(0, "h24_07_tens", 0);
    show(4, "h24_07_units", 7);
    // 12:34:56 layout sweep.
    do_reset();
    adj(1'b1, 1'b0, 1'b0, 12);
    adj(1'b0, 1'b1, 1'b0, 34);
    adj(1'b0, 1'b0, 1'b1, 1);
    step(224);
    tk.x_block = 6'd19;
    step();
    check("x19_number", 32'(tk.number), 4);
    check("x19_number_hhmm", 32'(tk5.number), 4);
    tk.x_block = 6'd20;
    step();
    check("x20_number", 32'(tk.number), 10);
    check("x20_number_hhmm", 32'(tk5.number), 11);
    tk.x_block = 6'd32;
    step();
    check("x32_number", 32'(tk.number), 11);
    check("x32_number_hhmm", 32'(tk5.number), 11);
    for (int x = 0; x <= 40; x++) begin
      tk.x_block = 6'(x);
      step();
    end
    adj(1'b0, 1'b0, 1'b1, 1);
    for (int i = 0; i < 4; i++) begin
`ifdef COLON_BLINK_EN
      exp_colon = i >= 2 ? 11 : 10;
`else
      exp_colon = 10;
`endif
      show(8, "colon_phase", exp_colon);
    end
    step(2);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
